// File: rtl/sr_ctrl_pkg.sv
// Shared command encodings and default sizing for the SR flag sequencer.
package sr_ctrl_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_NFLAGS = 8;
endpackage

// File: rtl/sr_rr_arbiter.sv
// Round-robin arbiter: combinational pick searching upward from a registered pointer.
module sr_rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   win_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    grant_o = '0;
    win_o   = '0;
    found   = 1'b0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && elig_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        win_o      = PW'(j);
      end
    end
    // Pointer moves just past the winner so it has lowest priority next time.
    if (found) ptr_d = (int'(win_o) == NREQ - 1) ? '0 : win_o + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_flag_sequencer.sv
// Bank of SR flag bits written by NREQ requesters through a round-robin arbiter,
// with sticky detection of illegal (set+reset) commands.
module sr_flag_sequencer
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int NFLAGS = DEF_NFLAGS,
  parameter int IDXW   = $clog2(NFLAGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_s,
  input  logic [NREQ-1:0]        req_r,
  input  logic [NREQ*IDXW-1:0]   req_idx,
  input  logic                   err_clr,
  output logic [NREQ-1:0]        gnt,
  output logic [NFLAGS-1:0]      q,
  output logic [NFLAGS-1:0]      qb,
  output logic                   err,
  output logic [$clog2(NREQ)-1:0] err_id
);

  localparam int RW = $clog2(NREQ);

  logic [NREQ-1:0]   gnt_q, grant;
  logic [RW-1:0]     win;
  logic [NFLAGS-1:0] q_q, q_d;
  logic              err_q, err_d;
  logic [RW-1:0]     err_id_q, err_id_d;
  logic [1:0]        cmd_op;
  logic [IDXW-1:0]   cmd_idx;
  logic              idx_ok;

  // Masking on the registered grant keeps a requester from winning again
  // while it is still dropping req after seeing its grant.
  sr_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_i (req & ~gnt_q),
    .grant_o(grant),
    .win_o  (win)
  );

  assign cmd_op  = {req_s[win], req_r[win]};
  assign cmd_idx = req_idx[int'(win)*IDXW +: IDXW];
  assign idx_ok  = 32'(cmd_idx) < 32'(NFLAGS);

  always_comb begin
    q_d      = q_q;
    err_d    = err_q;
    err_id_d = err_id_q;
    if (err_clr) err_d = 1'b0;
    if (|grant && idx_ok) begin
      case (cmd_op)
        OP_SET: q_d[cmd_idx] = 1'b1;
        OP_RST: q_d[cmd_idx] = 1'b0;
        OP_ILL: begin
          // A new error overrides a same-cycle clear and re-captures the source.
          if (!err_q || err_clr) err_id_d = win;
          err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      gnt_q    <= grant;
      q_q      <= q_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign q      = q_q;
  assign qb     = ~q_q;
  assign err    = err_q;
  assign err_id = err_id_q;

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Directed and randomized checks of sr_flag_sequencer against a queue-free behavioural model.
module tb_sr_flag_sequencer;
  localparam int NREQ = 4, NFLAGS = 8, IDXW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0, req_s = '0, req_r = '0;
  logic [NREQ*IDXW-1:0] req_idx = '0;
  logic err_clr = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [NFLAGS-1:0] q, qb;
  logic err;
  logic [1:0] err_id;

  int chk = 0, pass = 0;

  // reference model state
  int m_ptr = 0;
  logic [NFLAGS-1:0] m_q = '0;
  logic m_err = 1'b0;
  int m_eid = 0;
  logic [NREQ-1:0] m_gnt = '0;

  sr_flag_sequencer #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_s(req_s), .req_r(req_r),
    .req_idx(req_idx), .err_clr(err_clr), .gnt(gnt), .q(q), .qb(qb),
    .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  // Apply the rules for one clock edge using the inputs present before it.
  function automatic void model_edge();
    int win;
    logic [NREQ-1:0] elig;
    int idx;
    if (rst) begin
      m_ptr = 0; m_q = '0; m_err = 1'b0; m_eid = 0; m_gnt = '0;
      return;
    end
    elig = req & ~m_gnt;
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && elig[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    if (err_clr) m_err = 1'b0;
    m_gnt = '0;
    if (win >= 0) begin
      m_gnt[win] = 1'b1;
      m_ptr = (win + 1) % NREQ;
      idx = int'(req_idx[win*IDXW +: IDXW]);
      if (req_s[win] && !req_r[win]) m_q[idx] = 1'b1;
      else if (!req_s[win] && req_r[win]) m_q[idx] = 1'b0;
      else if (req_s[win] && req_r[win]) begin
        if (!m_err) m_eid = win;
        m_err = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input bit s, input bit r, input int idx);
    req_s[i] = s;
    req_r[i] = r;
    req_idx[i*IDXW +: IDXW] = 3'(idx);
    req[i] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1; req_s = '0; req_r = '0;
    tick(); tick();
    chk++; if (q !== 8'h00) $display("FAIL reset_q: got %h exp 00", q); else pass++;
    chk++; if (qb !== 8'hFF) $display("FAIL reset_qb: got %h exp FF", qb); else pass++;
    chk++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b exp 0000", gnt); else pass++;
    chk++; if (err !== 1'b0 || err_id !== 2'd0) $display("FAIL reset_err: got %b/%0d exp 0/0", err, err_id); else pass++;
    rst = 1'b0;
    tick();
    chk++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b exp 0001", gnt); else pass++;
    req = '0;
    tick();
  endtask

  task automatic test_basic();
    set_cmd(0, 1, 0, 3);
    tick();
    chk++; if (gnt !== 4'b0001 || q !== 8'h08) $display("FAIL basic_set: got gnt=%b q=%h exp 0001/08", gnt, q); else pass++;
    set_cmd(0, 0, 1, 3);
    tick();
    chk++; if (gnt !== 4'b0000) $display("FAIL basic_mask: got gnt=%b exp 0000", gnt); else pass++;
    tick();
    chk++; if (gnt !== 4'b0001 || q !== 8'h00) $display("FAIL basic_rst: got gnt=%b q=%h exp 0001/00", gnt, q); else pass++;
    set_cmd(0, 0, 0, 3);
    tick(); tick();
    chk++; if (gnt !== 4'b0001 || q !== 8'h00) $display("FAIL basic_hold: got gnt=%b q=%h exp 0001/00", gnt, q); else pass++;
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] prev;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1, 0, i);
    prev = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk++;
      if (gnt !== 4'(1 << (k % NREQ)) || gnt === prev)
        $display("FAIL rr_order%0d: got %b exp %b", k, gnt, 4'(1 << (k % NREQ)));
      else pass++;
      prev = gnt;
      if (k == 3) begin
        chk++; if (q !== 8'h0F) $display("FAIL rr_q: got %h exp 0F", q); else pass++;
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_contention();
    rst = 1'b1; tick(); rst = 1'b0;
    set_cmd(1, 1, 0, 5);
    set_cmd(2, 0, 1, 5);
    tick();
    chk++; if (gnt !== 4'b0010 || q[5] !== 1'b1) $display("FAIL cont_first: got gnt=%b q5=%b exp 0010/1", gnt, q[5]); else pass++;
    req[1] = 1'b0;
    tick();
    chk++; if (gnt !== 4'b0100 || q[5] !== 1'b0) $display("FAIL cont_second: got gnt=%b q5=%b exp 0100/0", gnt, q[5]); else pass++;
    req = '0;
    tick();
  endtask

  task automatic test_illegal();
    set_cmd(0, 1, 0, 0);
    tick();
    req = '0; set_cmd(2, 1, 1, 0);
    tick();
    chk++; if (q[0] !== 1'b1 || err !== 1'b1 || err_id !== 2'd2) $display("FAIL ill_first: got q0=%b err=%b id=%0d exp 1/1/2", q[0], err, err_id); else pass++;
    req = '0; set_cmd(3, 1, 1, 1);
    tick();
    chk++; if (gnt !== 4'b1000 || err !== 1'b1 || err_id !== 2'd2) $display("FAIL ill_sticky: got gnt=%b err=%b id=%0d exp 1000/1/2", gnt, err, err_id); else pass++;
    req = '0; set_cmd(1, 1, 1, 2); err_clr = 1'b1;
    tick();
    chk++; if (err !== 1'b1 || err_id !== 2'd1) $display("FAIL ill_clr_race: got err=%b id=%0d exp 1/1", err, err_id); else pass++;
    req = '0;
    tick();
    chk++; if (err !== 1'b0) $display("FAIL ill_clr: got err=%b exp 0", err); else pass++;
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    set_cmd(0, 1, 0, 0); set_cmd(1, 1, 0, 2); set_cmd(2, 1, 0, 5); set_cmd(3, 1, 0, 7);
    tick(); tick(); tick(); tick();
    chk++; if (q !== 8'hA5) $display("FAIL mid_setup: got %h exp A5", q); else pass++;
    req = '0;
    set_cmd(0, 1, 0, 1); set_cmd(1, 1, 0, 3);
    rst = 1'b1;
    tick();
    chk++; if (q !== 8'h00 || gnt !== 4'b0000 || qb !== 8'hFF) $display("FAIL mid_reset: got q=%h gnt=%b qb=%h exp 00/0000/FF", q, gnt, qb); else pass++;
    rst = 1'b0;
    tick();
    chk++; if (gnt !== 4'b0001 || q !== 8'h02) $display("FAIL mid_resume: got gnt=%b q=%h exp 0001/02", gnt, q); else pass++;
    req[0] = 1'b0;
    tick();
    chk++; if (gnt !== 4'b0010 || q !== 8'h0A) $display("FAIL mid_next: got gnt=%b q=%h exp 0010/0A", gnt, q); else pass++;
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(NFLAGS - 1, 0)));
        end else if (!req[i] && $urandom_range(9, 0) < 4) begin
          set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(NFLAGS - 1, 0)));
        end
      end
      err_clr = ($urandom_range(9, 0) == 0);
      tick();
      chk++;
      if ({gnt, q, qb, err, err_id} !== {m_gnt, m_q, ~m_q, m_err, 2'(m_eid)})
        $display("FAIL rand%0d: got gnt=%b q=%h qb=%h err=%b id=%0d exp gnt=%b q=%h err=%b id=%0d",
                 c, gnt, q, qb, err, err_id, m_gnt, m_q, m_err, m_eid);
      else pass++;
    end
    req = '0; err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_contention();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
